// File: rtl/data_mem_responder.sv
// Memory-stage data responder: one outstanding load/store serviced against a
// word-addressed RAM after LATENCY cycles, with valid/ready on both channels.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_strb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    strb_q, strb_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   off, widx;
    logic          addr_err, access, ram_we;
    logic [31:0]   mem [DEPTH_WORDS];

    // Underflow is caught by the explicit compare, so a wrapped offset never aliases.
    assign off      = addr_q - BASE_ADDR;
    assign widx     = off >> 2;
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                      (widx >= 32'(DEPTH_WORDS));
    assign access   = (state_q == WAIT) && (cnt_q == '0);
    assign ram_we   = access && write_q && !addr_err;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    strb_d  = req_strb;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    err_d   = addr_err;
                    rdata_d = (addr_err || write_q) ? 32'h0 : mem[widx[AW-1:0]];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            strb_q  <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM is not reset; reset forces IDLE, which kills ram_we for a pending store.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) mem[widx[AW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: scoreboard of expected responses,
// LATENCY=2 instance for function/stall/reset, LATENCY=1 instance for throughput.
module tb_data_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_strb;
    logic        req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_err1;
    logic [31:0] req_addr1, req_wdata1, resp_rdata1;
    logic [3:0]  req_strb1;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_strb(req_strb1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] ref_mem [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: range computed in 64-bit byte space, independent of the RTL.
    task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output exp_t e);
        longint unsigned la, lim;
        int              idx;
        logic [31:0]     old;
        bit              err;
        la  = longint'(a);
        lim = longint'(BASE) + longint'(4 * DEPTH);
        err = (a[1:0] != 2'b00) || (la < longint'(BASE)) || (la >= lim);
        e.err   = err;
        e.rdata = 32'h0;
        if (!err) begin
            idx = int'((la - longint'(BASE)) / 4);
            old = ref_mem.exists(idx) ? ref_mem[idx] : 32'hxxxx_xxxx;
            if (w) begin
                for (int i = 0; i < 4; i++) if (s[i]) old[8*i +: 8] = d[8*i +: 8];
                ref_mem[idx] = old;
            end else begin
                e.rdata = old;
            end
        end
    endtask

    // One transaction on the LATENCY=2 instance, optionally stalling the response.
    task automatic xact(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input int stall);
        exp_t        e;
        int          lat;
        logic [31:0] hold_rd;
        logic        hold_err;
        @(negedge clk);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
        resp_ready = 1'b0;
        @(posedge clk);
        model(w, a, d, s, e);
        q0.push_back(e);
        @(negedge clk);
        req_valid = 1'b0; req_write = ~w; req_addr = a ^ 32'h4; req_wdata = ~d; req_strb = ~s;
        chk({tag, "_wait_valid"}, 32'(resp_valid), 32'd0);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(lat), 32'd2);
        if (resp_valid) begin
            chk({tag, "_sb_depth"}, 32'(q0.size()), 32'd1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk({tag, "_rdata"}, resp_rdata, e.rdata);
                chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
            end
            hold_rd = resp_rdata; hold_err = resp_err;
            for (int i = 0; i < stall; i++) begin
                req_valid = 1'b1;
                @(posedge clk); @(negedge clk);
                chk({tag, "_stall_valid"}, 32'(resp_valid), 32'd1);
                chk({tag, "_stall_rdata"}, resp_rdata, hold_rd);
                chk({tag, "_stall_err"}, 32'(resp_err), 32'(hold_err));
                chk({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0; resp_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            resp_ready = 1'b0;
            chk({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
            chk({tag, "_done_rdata"}, resp_rdata, 32'h0);
            chk({tag, "_done_err"}, 32'(resp_err), 32'd0);
            chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        exp_t e;
        int   acc, prev, t;
        resetn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
        resp_ready = 1'b0;
        req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_strb1 = '0;
        resp_ready1 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_resp_valid1", 32'(resp_valid1), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_req_ready1", 32'(req_ready1), 32'd1);

        xact("st_full",    1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 0);
        xact("ld_full",    1'b0, 32'h10,   32'h0,        4'h0, 0);
        xact("st_lane0",   1'b1, 32'h10,   32'h000000AA, 4'b0001, 0);
        xact("ld_lane0",   1'b0, 32'h10,   32'h0,        4'h0, 0);
        xact("st_nostrb",  1'b1, 32'h10,   32'hFFFFFFFF, 4'b0000, 0);
        xact("ld_nostrb",  1'b0, 32'h10,   32'h0,        4'h0, 0);
        xact("ld_misal",   1'b0, 32'h13,   32'h0,        4'h0, 0);
        xact("ld_oor",     1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, 0);
        xact("st_misal",   1'b1, 32'h12,   32'h00000000, 4'hF, 0);
        xact("st_oor",     1'b1, BASE + 32'(4 * DEPTH) + 32'h10, 32'h0, 4'hF, 0);
        xact("ld_stall",   1'b0, 32'h10,   32'h0,        4'h0, 5);
        xact("st_last",    1'b1, BASE + 32'(4 * DEPTH - 4), 32'h5A5A5A5A, 4'hF, 0);
        xact("ld_last",    1'b0, BASE + 32'(4 * DEPTH - 4), 32'h0, 4'h0, 0);
        xact("st_0x20",    1'b1, 32'h20,   32'h12345678, 4'hF, 0);

        // Store dropped by reset while waiting; the model is deliberately not updated.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_strb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rstw_valid", 32'(resp_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("rstw_valid_hold", 32'(resp_valid), 32'd0);
        chk("rstw_rdata", resp_rdata, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rstw_req_ready", 32'(req_ready), 32'd1);
        chk("rstw_valid_after", 32'(resp_valid), 32'd0);
        xact("ld_0x20",    1'b0, 32'h20,   32'h0,        4'h0, 0);

        // LATENCY=1 instance, resp_ready tied high, request always offered.
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            t = 0;
            while (!req_ready1 && t < 10) begin @(negedge clk); t++; end
            chk("l1_ready_timeout", 32'(req_ready1), 32'd1);
            req_valid1 = 1'b1;
            req_write1 = (k == 0);
            req_addr1  = 32'h40;
            req_wdata1 = (k == 0) ? 32'hCAFEF00D : 32'h0;
            req_strb1  = (k == 0) ? 4'hF : 4'h0;
            @(posedge clk);
            e.rdata = (k == 0) ? 32'h0 : 32'hCAFEF00D;
            e.err   = 1'b0;
            q1.push_back(e);
            @(negedge clk);
            acc = cyc;
            chk("l1_wait_valid", 32'(resp_valid1), 32'd0);
            if (k > 0) chk("l1_spacing", 32'(acc - prev), 32'd3);
            prev = acc;
            @(negedge clk);
            chk("l1_resp_valid", 32'(resp_valid1), 32'd1);
            chk("l1_sb_depth", 32'(q1.size()), 32'd1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("l1_rdata", resp_rdata1, e.rdata);
                chk("l1_err", 32'(resp_err1), 32'(e.err));
            end
        end
        req_valid1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
